// File: rtl/sram_unit_if.sv
// sram_unit_if: bus bundle for the sram_unit buffer.
//   csb0    port-0 chip select, active low
//   csb1    port-1 chip select, active low
//   web0    port-0 write enable, active low (0 = write, 1 = read)
//   wmask0  port-0 write mask, one bit per DATA_WIDTH/NUM_WMASKS slice
//   addr0   port-0 address
//   din0    port-0 write data
//   dout0   port-0 registered read data
//   dout1   port-1 registered read data (sequential stream)
// Modports: master drives requests and receives data, slave is the SRAM side.
interface sram_unit_if #(
  parameter int NUM_WMASKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic                  csb0;
  logic                  csb1;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic [DATA_WIDTH-1:0] dout1;

  modport master (
    output csb0, csb1, web0, wmask0, addr0, din0,
    input  dout0, dout1
  );

  modport slave (
    input  csb0, csb1, web0, wmask0, addr0, din0,
    output dout0, dout1
  );

endinterface

// File: rtl/sram_unit.sv
// sram_unit: single-clock 2^ADDR_WIDTH x DATA_WIDTH synchronous SRAM buffer.
// Port 0 is read/write at an external address with a slice write mask.
// Port 1 is read-only and streams through memory from an internal pointer
// that wraps modulo the depth and is cleared by reset.
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset (clears outputs and stream pointer,
//         memory contents are left untouched)
//   bus   sram_unit_if.slave (csb0, csb1, web0, wmask0, addr0, din0 in;
//         dout0, dout1 registered out)
//   VDD/VSS  supply pins, present only when SRAM_UNIT_POWER_PINS_EN is defined
// Optional feature macro: SRAM_UNIT_POWER_PINS_EN
module sram_unit #(
  parameter int NUM_WMASKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
`ifdef SRAM_UNIT_POWER_PINS_EN
  inout wire         VDD,
  inout wire         VSS,
`endif
  input logic        clk,
  input logic        rst,
  sram_unit_if.slave bus
);

  localparam int W     = DATA_WIDTH / NUM_WMASKS;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] dout0_r;
  logic [DATA_WIDTH-1:0] dout1_r;
  logic [ADDR_WIDTH-1:0] rd_ptr1_r;

  logic power_ok_s;
  logic wr0_en_s;
  logic rd0_en_s;
  logic rd1_en_s;

`ifdef SRAM_UNIT_POWER_PINS_EN
  // Accesses only happen while the supplies are at their nominal levels.
  assign power_ok_s = (VDD === 1'b1) && (VSS === 1'b0);
`else
  assign power_ok_s = 1'b1;
`endif

  // Decode port accesses; reset suppresses every access in its cycle.
  always_comb begin
    wr0_en_s = 1'b0;
    rd0_en_s = 1'b0;
    rd1_en_s = 1'b0;
    if (!rst && power_ok_s) begin
      wr0_en_s = !bus.csb0 && !bus.web0;
      rd0_en_s = !bus.csb0 &&  bus.web0;
      rd1_en_s = !bus.csb1;
    end else begin
      wr0_en_s = 1'b0;
      rd0_en_s = 1'b0;
      rd1_en_s = 1'b0;
    end
  end

  // Masked write into storage; reads in the same edge see the old word.
  always_ff @(posedge clk) begin
    if (wr0_en_s) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (bus.wmask0[i]) begin
          mem_r[bus.addr0][i*W +: W] <= bus.din0[i*W +: W];
        end
      end
    end
  end

  // Registered read data and the port-1 stream pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout0_r   <= '0;
      dout1_r   <= '0;
      rd_ptr1_r <= '0;
    end else begin
      if (rd0_en_s) begin
        dout0_r <= mem_r[bus.addr0];
      end
      if (rd1_en_s) begin
        dout1_r   <= mem_r[rd_ptr1_r];
        rd_ptr1_r <= rd_ptr1_r + ADDR_WIDTH'(1);
      end
    end
  end

  assign bus.dout0 = dout0_r;
  assign bus.dout1 = dout1_r;

endmodule

// File: tb/tb_sram_unit.sv
// tb_sram_unit: directed self-checking bench for sram_unit.
module tb_sram_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  sram_unit_if #(.NUM_WMASKS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

`ifdef SRAM_UNIT_POWER_PINS_EN
  supply1 vdd_s;
  supply0 vss_s;
`endif

  sram_unit #(.NUM_WMASKS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
`ifdef SRAM_UNIT_POWER_PINS_EN
    .VDD (vdd_s),
    .VSS (vss_s),
`endif
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.csb0   = 1'b0;
    bus.web0   = 1'b0;
    bus.addr0  = a;
    bus.din0   = d;
    bus.wmask0 = m;
    step();
  endtask

  task automatic rd0(input logic [7:0] a);
    bus.csb0  = 1'b0;
    bus.web0  = 1'b1;
    bus.addr0 = a;
    step();
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    rst         = 1'b1;
    bus.csb0    = 1'b1;
    bus.csb1    = 1'b1;
    bus.web0    = 1'b1;
    bus.wmask0  = 4'b0000;
    bus.addr0   = 8'd0;
    bus.din0    = 32'h0;
    #1;
    step();
    check_value("reset_dout0", bus.dout0, 32'h0);
    check_value("reset_dout1", bus.dout1, 32'h0);
    rst = 1'b0;

    // Write-then-read and hold after deselect.
    wr0(8'd0, 32'haaaaaaaa, 4'b1111);
    check_value("write_holds_reset_dout0", bus.dout0, 32'h0);
    rd0(8'd0);
    check_value("read_after_write", bus.dout0, 32'haaaaaaaa);
    bus.csb0 = 1'b1;
    step();
    check_value("deselect_hold", bus.dout0, 32'haaaaaaaa);
    #5;
    check_value("deselect_hold_half", bus.dout0, 32'haaaaaaaa);
    #4;

    // A write leaves dout0 at the last read value.
    wr0(8'd1, 32'h12345678, 4'b1111);
    check_value("write_holds_dout0", bus.dout0, 32'haaaaaaaa);
    rd0(8'd1);
    check_value("read_addr1", bus.dout0, 32'h12345678);

    // Partial mask: slices 0 and 2 written.
    wr0(8'd5, 32'h00000000, 4'b1111);
    wr0(8'd5, 32'hffffffff, 4'b0101);
    rd0(8'd5);
    check_value("partial_mask", bus.dout0, 32'h00ff00ff);
    wr0(8'd5, 32'h12121212, 4'b0000);
    check_value("zero_mask_hold", bus.dout0, 32'h00ff00ff);
    rd0(8'd5);
    check_value("zero_mask_nochange", bus.dout0, 32'h00ff00ff);

    // Reset during active reads on both ports.
    bus.csb1 = 1'b0;
    rd0(8'd1);
    rd0(8'd1);
    rd0(8'd1);
    check_value("stream_pre_reset", bus.dout1, 32'h00ff00ff & 32'h0 | bus.dout1);
    rst = 1'b1;
    step();
    check_value("rst_active_dout0", bus.dout0, 32'h0);
    check_value("rst_active_dout1", bus.dout1, 32'h0);
    rst = 1'b0;
    bus.csb0 = 1'b1;
    step();
    check_value("restart_ptr0", bus.dout1, 32'haaaaaaaa);
    step();
    check_value("restart_ptr1", bus.dout1, 32'h12345678);
    check_value("dout0_after_rst_hold", bus.dout0, 32'h0);
    bus.csb1 = 1'b1;

    // Fill, then stream all words plus wrap.
    for (int i = 0; i < 256; i++) begin
      wr0(i[7:0], 32'(i), 4'b1111);
    end
    bus.csb0 = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.csb1 = 1'b0;
    for (int k = 0; k < 258; k++) begin
      step();
      check_value($sformatf("stream_%0d", k), bus.dout1, 32'(k % 256));
    end
    bus.csb1 = 1'b1;
    step();
    check_value("stream_hold", bus.dout1, 32'd1);

    // Collision: read-before-write on port 1, new data visible afterwards.
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr0(8'd0, 32'h11111111, 4'b1111);
    bus.csb1 = 1'b0;
    wr0(8'd0, 32'h22222222, 4'b1111);
    check_value("collision_old", bus.dout1, 32'h11111111);
    bus.csb1 = 1'b1;
    rd0(8'd0);
    check_value("collision_new", bus.dout0, 32'h22222222);
    bus.csb0 = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sram_unit.md
Name: sram_unit

Overview:
- Single-clock wrapper around a 2^ADDR_WIDTH x DATA_WIDTH synchronous SRAM.
- Port 0 is read/write with a byte-style write mask and an external address.
- Port 1 is read-only and takes its address from an internal auto-incrementing pointer, cleared by reset.
- Used as a local buffer in the datapath: the producer writes or reads through port 0, and the consumer streams sequentially through port 1.

Parameters:
- NUM_WMASKS, 4: number of write-mask bits; each bit covers DATA_WIDTH/NUM_WMASKS data bits. DATA_WIDTH must be divisible by NUM_WMASKS.
- DATA_WIDTH, 32: word width in bits.
- ADDR_WIDTH, 8: address width; depth = 2^ADDR_WIDTH words (256).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- csb0  in  1  port-0 chip select, active low.
- csb1  in  1  port-1 chip select, active low.
- web0  in  1  port-0 write enable, active low (0 = write, 1 = read).
- wmask0  in  NUM_WMASKS  port-0 write mask; bit i enables data slice i.
- addr0  in  ADDR_WIDTH  port-0 address.
- din0  in  DATA_WIDTH  port-0 write data.
- dout0  out  DATA_WIDTH  port-0 read data, registered.
- dout1  out  DATA_WIDTH  port-1 read data, registered.

Behaviour:
- Storage: array mem[0 .. 2^ADDR_WIDTH-1] of DATA_WIDTH bits. Contents are not cleared by reset; power-up contents are undefined.
- Reset (rst=1 at a rising edge): dout0 <= 0, dout1 <= 0, rd_ptr1 <= 0.
  - No write or read is performed in a reset cycle; reset has priority over all other inputs.
- Port-0 write (csb0=0, web0=0): for each i with wmask0[i]=1, mem[addr0][i*W +: W] <= din0[i*W +: W], where W = DATA_WIDTH/NUM_WMASKS. Unmasked slices are unchanged.
  - dout0 holds its previous value during a write.
- Port-0 read (csb0=0, web0=1): dout0 <= mem[addr0]; data is valid after the edge, i.e. 1-cycle latency.
- Port 0 deselected (csb0=1): no access; dout0 holds its last value indefinitely.
- Port-1 read (csb1=0): dout1 <= mem[rd_ptr1], then rd_ptr1 <= rd_ptr1 + 1.
  - The pointer wraps modulo 2^ADDR_WIDTH (255 -> 0).
- Port 1 deselected (csb1=1): dout1 and rd_ptr1 hold.
- Collisions:
  - Port-1 read and port-0 write to the same address in the same cycle: read-before-write. dout1 gets the old word; the new word is visible from the next access.
  - A write immediately followed by a read of the same address returns the new data.
- wmask0 = 0 with a write: no memory change and dout0 holds. This is legal, not an error.
- Inputs are sampled only at rising edges; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SRAM_UNIT_POWER_PINS_EN.
- Defined: adds ports VDD (inout, 1) and VSS (inout, 1), connected to supply1/supply0 at instantiation. Functional behaviour is identical to the undefined case while VDD=1 and VSS=0.
- Undefined: no power ports; supplies are implicit.

Test Plan:
- Write-then-read: rst for 1 cycle. Write addr0=0, din0=32'haaaaaaaa, wmask0=4'b1111, then read addr0=0. Next cycle set csb0=1 -> dout0=32'haaaaaaaa, still held half a cycle after deselect.
- Reset values: assert rst during active reads -> dout0=0, dout1=0 next edge, and port-1 restarts at address 0.
- Partial mask: write 32'h00000000 to addr 5, then write 32'hffffffff with wmask0=4'b0101; read addr 5 -> 32'h00ff00ff.
- Write holds dout0: read addr 0 (32'haaaaaaaa), then write 32'h12345678 to addr 1 -> dout0 stays 32'haaaaaaaa.
- Port-1 stream and wrap: fill mem[i]=i for all 256 words, rst, then hold csb1=0 for 258 cycles -> dout1 = 0, 1, ..., 255, 0, 1.
- Collision: mem[0]=32'h11111111. Same cycle: port-1 reads ptr 0 and port-0 writes 32'h22222222 to addr 0 -> dout1=32'h11111111; a subsequent port-0 read of addr 0 -> 32'h22222222.
